fifo_word_serializer: RTL and testbench

//   Downstream drain stage for the word FIFO. Pops one BITS-wide word whenever the FIFO reports data and

---
 rtl/fifo_ser_pkg.sv | 16 +
 rtl/ser_bit_tick.sv | 34 +++
 rtl/fifo_word_serializer.sv | 134 +++++++++++++
 tb/tb_fifo_word_serializer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ser_pkg.sv
// Shared types and sizing helpers for the FIFO word serializer.
package fifo_ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } ser_state_t;

  // Bits needed to hold a counter running 0..n-1, never narrower than 1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ser_bit_tick.sv
// Serial bit-period divider: emits one tick on the last clock of every CLK_DIV-clock bit period.
module ser_bit_tick
  import fifo_ser_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;

  assign tick = run && (div_cnt_q == DIV_LAST);

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear || tick) div_cnt_d = '0;
    else if (run)      div_cnt_d = div_cnt_q + DW'(1);
  end

  // NOTE: state flops use non-blocking assignments and reset asynchronously on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops words from the word FIFO and shifts them out MSB-first with a frame strobe.
// Optional even-parity bit after the LSB when FIFO_SER_PARITY_EN is defined.
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int BITS     = 12,
  parameter int CLK_DIV  = 4,
  parameter int GAP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            fifo_ready,
  input  logic [BITS-1:0] fifo_data,
  output logic            fifo_read,
  output logic            ser_data,
  output logic            ser_frame,
  output logic            busy,
  output logic            word_done
);

  localparam int BW = cnt_width(BITS);
  localparam int GW = cnt_width(GAP_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam ser_state_t POST_FRAME = (GAP_BITS > 0) ? GAP : IDLE;

  ser_state_t      state_q, state_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            tick;
`ifdef FIFO_SER_PARITY_EN
  logic            parity_q, parity_d;
`endif

  ser_bit_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (fifo_read),
    .run   (busy),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
`ifdef FIFO_SER_PARITY_EN
    parity_d  = parity_q;
`endif
    fifo_read = 1'b0;
    word_done = 1'b0;
    case (state_q)
      IDLE: if (enable && fifo_ready) begin
        fifo_read = 1'b1;
        shift_d   = fifo_data;
        bit_cnt_d = BIT_LAST;
        gap_cnt_d = '0;
`ifdef FIFO_SER_PARITY_EN
        parity_d  = ^fifo_data;
`endif
        state_d   = SHIFT;
      end
      SHIFT: if (tick) begin
        if (bit_cnt_q == '0) begin
`ifdef FIFO_SER_PARITY_EN
          state_d   = PARITY;
`else
          word_done = 1'b1;
          state_d   = POST_FRAME;
`endif
        end else begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q - BW'(1);
        end
      end
`ifdef FIFO_SER_PARITY_EN
      PARITY: if (tick) begin
        word_done = 1'b1;
        state_d   = POST_FRAME;
      end
`endif
      GAP: if (tick) begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
`ifdef FIFO_SER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
`ifdef FIFO_SER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Line outputs depend only on flops so they cannot glitch on input changes.
  always_comb begin
    ser_data  = 1'b0;
    ser_frame = 1'b0;
    case (state_q)
      SHIFT: begin
        ser_data  = shift_q[BITS-1];
        ser_frame = 1'b1;
      end
`ifdef FIFO_SER_PARITY_EN
      PARITY: begin
        ser_data  = parity_q;
        ser_frame = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer (BITS=12, CLK_DIV=4, GAP_BITS=1), with or without FIFO_SER_PARITY_EN.
module tb_fifo_word_serializer;

`ifdef FIFO_SER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int BITS = 12, DIV = 4, G = 1;
  localparam int FRAME  = (BITS + P + G) * DIV;
  localparam int FRAMED = (BITS + P) * DIV;
  localparam int PERIOD = FRAME + 1;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, fifo_ready = 1'b0;
  logic [BITS-1:0] fifo_data = '0;
  logic fifo_read, ser_data, ser_frame, busy, word_done;
  int n_vec = 0, n_err = 0;

  fifo_word_serializer #(.BITS(BITS), .CLK_DIV(DIV), .GAP_BITS(G)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_ready(fifo_ready),
    .fifo_data(fifo_data), .fifo_read(fifo_read), .ser_data(ser_data),
    .ser_frame(ser_frame), .busy(busy), .word_done(word_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BITS-1:0] data;
    logic [BITS-1:0] exp_bits;
    logic            exp_par;
    string           name;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 4 * PERIOD; i++) begin
      @(negedge clk); #1;
      if (!busy) break;
    end
    check({name, "_idle_timeout"}, busy, 0);
  endtask

  // One word through an idle DUT, sampled every clock of the frame.
  task automatic run_frame(input logic [BITS-1:0] w, input logic [BITS-1:0] exp_bits,
                           input logic exp_par, input string name);
    logic [BITS-1:0] bits;
    logic par, last;
    int frame_cnt, done_cnt, done_pos, rd_cnt, held_err, gap_err, i;
    bits = '0; par = 1'b0; last = 1'b0;
    frame_cnt = 0; done_cnt = 0; done_pos = -1; rd_cnt = 0; held_err = 0; gap_err = 0;
    @(negedge clk);
    fifo_data = w; fifo_ready = 1'b1; enable = 1'b1;
    #1 check({name, "_pop"}, fifo_read, 1);
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      if (c == 1) fifo_ready = 1'b0;
      #1;
      i = (c - 1) / DIV;
      if (ser_frame) frame_cnt++;
      if (fifo_read) rd_cnt++;
      if (word_done) begin done_cnt++; done_pos = c; end
      if (i < BITS + P) begin
        if ((c - 1) % DIV == 0) begin
          if (i < BITS) bits[BITS-1-i] = ser_data;
          else          par = ser_data;
        end else if (ser_data !== last) held_err++;
        last = ser_data;
      end else if (ser_data !== 1'b0 || ser_frame !== 1'b0) gap_err++;
    end
    check({name, "_bits"}, bits, exp_bits);
`ifdef FIFO_SER_PARITY_EN
    check({name, "_parity"}, par, exp_par);
`endif
    check({name, "_frame_clks"}, frame_cnt, FRAMED);
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_done_pos"}, done_pos, FRAMED);
    check({name, "_extra_reads"}, rd_cnt, 0);
    check({name, "_bit_hold"}, held_err, 0);
    check({name, "_gap_idle"}, gap_err, 0);
    @(negedge clk); #1;
    check({name, "_back_idle"}, busy, 0);
  endtask

  initial begin
    logic [BITS-1:0] words[3];
    int pops, last_t, gaps, gap_bad, cnt_rd, cnt_fr;
    bit pending;

    vecs[0] = '{12'hA5C, 12'hA5C, 1'b0, "a5c"};
    vecs[1] = '{12'h007, 12'h007, 1'b1, "007"};
    vecs[2] = '{12'hFFF, 12'hFFF, 1'b0, "fff"};
    vecs[3] = '{12'h800, 12'h800, 1'b1, "800"};
    vecs[4] = '{12'h001, 12'h001, 1'b1, "001"};
    vecs[5] = '{12'h000, 12'h000, 1'b0, "000"};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_fifo_read", fifo_read, 0);
    check("rst_ser_data", ser_data, 0);
    check("rst_ser_frame", ser_frame, 0);
    check("rst_busy", busy, 0);
    check("rst_word_done", word_done, 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[k]) run_frame(vecs[k].data, vecs[k].exp_bits, vecs[k].exp_par, vecs[k].name);

    // Back-to-back: three queued words with fifo_ready held high
    words[0] = 12'h123; words[1] = 12'h456; words[2] = 12'h789;
    pops = 0; last_t = 0; gaps = 0; gap_bad = 0; pending = 1'b0;
    @(negedge clk);
    enable = 1'b1; fifo_ready = 1'b1; fifo_data = words[0];
    for (int t = 0; t < 3 * PERIOD + 20; t++) begin
      if (t > 0) @(negedge clk);
      if (pending) begin
        pending = 1'b0;
        if (pops < 3) fifo_data = words[pops];
      end
      #1;
      if (fifo_read) begin
        pops++;
        if (pops > 1) check("b2b_spacing", t - last_t, PERIOD);
        last_t = t;
        pending = 1'b1;
        if (pops == 3) break;
      end
      if (pops >= 1 && busy && !ser_frame) begin
        gaps++;
        if (ser_data !== 1'b0) gap_bad++;
      end
    end
    check("b2b_pops", pops, 3);
    check("b2b_gap_clks", gaps, 2 * G * DIV);
    check("b2b_gap_data", gap_bad, 0);
    @(negedge clk); fifo_ready = 1'b0;
    wait_idle("b2b");

    // enable dropped at bit 5 mid-frame with data still queued
    cnt_rd = 0; cnt_fr = 0;
    @(negedge clk);
    enable = 1'b1; fifo_ready = 1'b1; fifo_data = 12'h3C5;
    #1 check("en_pop", fifo_read, 1);
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (c == 5 * DIV + 1) enable = 1'b0;
      #1;
      if (fifo_read) cnt_rd++;
      if (ser_frame) cnt_fr++;
    end
    check("en_no_pop", cnt_rd, 0);
    check("en_full_frame", cnt_fr, FRAMED);
    @(negedge clk); enable = 1'b1;
    #1 check("en_resume_pop", fifo_read, 1);
    @(negedge clk); fifo_ready = 1'b0;
    wait_idle("en");

    // Reset asserted during bit 7
    @(negedge clk);
    enable = 1'b1; fifo_ready = 1'b1; fifo_data = 12'hFFF;
    #1 check("rst_mid_pop", fifo_read, 1);
    @(negedge clk); fifo_ready = 1'b0;
    repeat (7 * DIV) @(negedge clk);
    #1;
    check("rst_mid_pre_data", ser_data, 1);
    check("rst_mid_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_data", ser_data, 0);
    check("rst_mid_frame", ser_frame, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_read", fifo_read, 0);
    @(negedge clk); rst_n = 1'b1;
    run_frame(12'h5A3, 12'h5A3, 1'b0, "post_rst");

    // Empty FIFO with enable high
    cnt_rd = 0; cnt_fr = 0; gaps = 0;
    @(negedge clk); enable = 1'b1; fifo_ready = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (fifo_read) cnt_rd++;
      if (busy) gaps++;
      if (ser_frame) cnt_fr++;
    end
    check("empty_read", cnt_rd, 0);
    check("empty_busy", gaps, 0);
    check("empty_frame", cnt_fr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
